// File: rtl/mips_mem_pkg.sv
// Shared constants and decode types for the MIPS data-port responder.
package mips_mem_pkg;

  localparam logic [31:0] CONSOLE_TX_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF     = 32'h0000_0004;
  localparam logic [31:0] CYCLE_OFF      = 32'h0000_0008;
  localparam logic [31:0] MMIO_SPAN      = 32'h0000_000C;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 6;

  localparam logic [31:0] UNMAPPED_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// CPU data port plus console drain channel of the responder.
interface mips_data_mem_responder_if;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;

  modport master (
    output data_address, data_write, data_read, data_writedata, console_ready,
    input  data_readdata, console_valid, console_data
  );

  modport slave (
    input  data_address, data_write, data_read, data_writedata, console_ready,
    output data_readdata, console_valid, console_data
  );
endinterface

// File: rtl/mips_data_mem_responder_byte_fifo.sv
// First-word fall-through byte FIFO; head reads as zero while empty.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Harvard data-port responder: word RAM, console TX FIFO, status and cycle counter MMIO.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_enable,
  mips_data_mem_responder_if.slave      bus,
  output logic                          err
);

  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_END = 33'(RAM_BASE) + 33'(RAM_WORDS) * 33'd4;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycle;
  logic [31:0] ram_off, mmio_off;
  logic [IW-1:0] ram_idx;
  logic        aligned, strobe;
  region_e     region;

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;
  logic          wr_ram, wr_console, wr_cycle, err_set;

  assign aligned  = (bus.data_address[1:0] == 2'b00);
  assign strobe   = bus.data_read || bus.data_write;
  assign ram_off  = bus.data_address - RAM_BASE;
  assign mmio_off = bus.data_address - MMIO_BASE;
  assign ram_idx  = ram_off[IW+1:2];

  always_comb begin
    region = REG_NONE;
    if ({1'b0, bus.data_address} >= {1'b0, RAM_BASE} && {1'b0, bus.data_address} < RAM_END)
      region = REG_RAM;
    else if (bus.data_address >= MMIO_BASE && mmio_off < MMIO_SPAN)
      region = REG_MMIO;
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
  end

  always_comb begin
    bus.data_readdata = '0;
    if (bus.data_read) begin
      if (!aligned || region == REG_NONE) bus.data_readdata = UNMAPPED_WORD;
      else if (region == REG_RAM)         bus.data_readdata = ram[ram_idx];
      else if (mmio_off == STATUS_OFF)    bus.data_readdata = status_word;
      else if (mmio_off == CYCLE_OFF)     bus.data_readdata = cycle;
    end
  end

  // Misaligned strobes never reach any target.
  always_comb begin
    wr_ram     = 1'b0;
    wr_console = 1'b0;
    wr_cycle   = 1'b0;
    if (bus.data_write && clk_enable && aligned) begin
      wr_ram     = (region == REG_RAM);
      wr_console = (region == REG_MMIO) && (mmio_off == CONSOLE_TX_OFF);
      wr_cycle   = (region == REG_MMIO) && (mmio_off == CYCLE_OFF);
    end
  end

  assign fifo_pop  = bus.console_valid && bus.console_ready;
  assign fifo_push = wr_console;
  assign err_set   = clk_enable && strobe &&
                     (!aligned || region == REG_NONE || (wr_console && fifo_full && !fifo_pop));

  always_ff @(posedge clk) begin
    if (wr_ram && !reset) ram[ram_idx] <= bus.data_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      err   <= 1'b0;
    end else if (clk_enable) begin
      cycle <= wr_cycle ? bus.data_writedata : cycle + 32'd1;
      if (err_set) err <= 1'b1;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.data_writedata[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (bus.console_data)
  );

  assign bus.console_valid = !fifo_empty;

endmodule
